// File: rtl/audio_mixer.sv
//-----------------------------------------------------------------------------
// audio_mixer
//
// Parametrised N-channel unsigned audio mixer. On each sample strobe the
// channel samples, gains and mutes are captured into shadow registers, then
// accumulated one channel per clock. The sum is saturated to OUT_W bits and
// registered on mix_out with a one-cycle mix_valid pulse.
//
// Optional feature (macro AUDIO_MIXER_PEAK_EN): adds a peak-hold output
// (peak_out), a sticky saturation flag (clip) and their clear (peak_clr).
//
// Ports:
//   CLKSYS       in   system clock
//   RESET        in   asynchronous active-high reset
//   sample_stb   in   one-cycle pulse, start mixing one sample
//   ch_data      in   NCH*IN_W channel samples, channel k at [k*IN_W +: IN_W]
//   ch_gain      in   NCH*GAIN_W gain codes, channel k at [k*GAIN_W +: GAIN_W]
//   ch_mute      in   NCH mute bits, 1 = channel contributes 0
//   overrun_clr  in   clears the sticky overrun flag
//   mix_out      out  last completed mixed sample
//   mix_valid    out  one-cycle pulse when mix_out updates
//   busy         out  high while a mix is in progress
//   overrun      out  sticky, a strobe arrived while busy
//   peak_out     out  (PEAK_EN) maximum mix_out since reset / last peak_clr
//   peak_clr     in   (PEAK_EN) clears peak_out and clip
//   clip         out  (PEAK_EN) sticky, a mix saturated
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module audio_mixer #(
    parameter int NCH     = 4,
    parameter int IN_W    = 16,
    parameter int GAIN_W  = 4,
    parameter int GAIN_SH = 3,
    parameter int OUT_W   = 16
) (
    input  logic                  CLKSYS,
    input  logic                  RESET,
    input  logic                  sample_stb,
    input  logic [NCH*IN_W-1:0]   ch_data,
    input  logic [NCH*GAIN_W-1:0] ch_gain,
    input  logic [NCH-1:0]        ch_mute,
    input  logic                  overrun_clr,
    output logic [OUT_W-1:0]      mix_out,
    output logic                  mix_valid,
    output logic                  busy,
`ifdef AUDIO_MIXER_PEAK_EN
    output logic [OUT_W-1:0]      peak_out,
    input  logic                  peak_clr,
    output logic                  clip,
`endif
    output logic                  overrun
);

    // Accumulator is wide enough that NCH full-scale products never wrap.
    localparam int AW = IN_W + GAIN_W + $clog2(NCH) + 1;
    localparam int PW = IN_W + GAIN_W;
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SAT
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0]     acc;
    logic [IW-1:0]     idx;
    logic              start;
    logic              acc_en;
    logic              done;

    logic [IN_W-1:0]   sh_data [NCH];
    logic [GAIN_W-1:0] sh_gain [NCH];
    logic [NCH-1:0]    sh_mute;

    logic [PW-1:0]     prod;
    logic [AW-1:0]     term;
    logic              sat_hit;
    logic [OUT_W-1:0]  acc_low;
    logic [OUT_W-1:0]  sat_val;

    //-------------------------------------------------------------------------
    // FSM
    //-------------------------------------------------------------------------
    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        acc_en   = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_stb) begin
                    start    = 1'b1;
                    state_nx = ACC;
                end
            end
            ACC: begin
                acc_en = 1'b1;
                if (idx == LAST_IDX) state_nx = SAT;
            end
            SAT: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    //-------------------------------------------------------------------------
    // Shadow capture of the channel inputs so they may change mid-mix.
    //-------------------------------------------------------------------------
    // NOTE: the shadow bank is pure datapath storage that is always written
    // before it is read, so it carries no reset; this keeps it a plain
    // register bank / memory without reset routing.
    always_ff @(posedge CLKSYS) begin
        if (start) begin
            for (int k = 0; k < NCH; k++) begin
                sh_data[k] <= ch_data[k*IN_W +: IN_W];
                sh_gain[k] <= ch_gain[k*GAIN_W +: GAIN_W];
            end
            sh_mute <= ch_mute;
        end
    end

    //-------------------------------------------------------------------------
    // Per-channel scaled contribution. Gain code 0 yields a zero product,
    // which makes it behave exactly like mute.
    //-------------------------------------------------------------------------
    always_comb begin
        prod = PW'(sh_data[idx]) * PW'(sh_gain[idx]);
        term = sh_mute[idx] ? '0 : AW'(prod >> GAIN_SH);
    end

    //-------------------------------------------------------------------------
    // Saturation to OUT_W. If the accumulator fits in OUT_W it cannot clip.
    //-------------------------------------------------------------------------
    if (AW > OUT_W) begin : g_sat
        assign sat_hit = |acc[AW-1:OUT_W];
        assign acc_low = acc[OUT_W-1:0];
    end else begin : g_nosat
        assign sat_hit = 1'b0;
        assign acc_low = OUT_W'(acc);
    end

    assign sat_val = sat_hit ? {OUT_W{1'b1}} : acc_low;

    //-------------------------------------------------------------------------
    // Accumulator, output register and status flags
    //-------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mix_valid <= done;

            if (start) begin
                acc <= '0;
                idx <= '0;
            end else if (acc_en) begin
                acc <= acc + term;
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end

            if (done) mix_out <= sat_val;

            // A strobe that lands while busy sets the flag; set beats clear.
            if (sample_stb && busy) overrun <= 1'b1;
            else if (overrun_clr)   overrun <= 1'b0;
        end
    end

`ifdef AUDIO_MIXER_PEAK_EN
    //-------------------------------------------------------------------------
    // Peak hold and clip flag, updated on the same edge as mix_out. A clear
    // coinciding with a completion restarts the peak from the new sample.
    //-------------------------------------------------------------------------
    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            peak_out <= '0;
            clip     <= 1'b0;
        end else begin
            if (done) begin
                if (peak_clr || (sat_val > peak_out)) peak_out <= sat_val;
            end else if (peak_clr) begin
                peak_out <= '0;
            end

            if (done && sat_hit) clip <= 1'b1;
            else if (peak_clr)   clip <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_audio_mixer.sv
`timescale 1ns/1ps

module tb_audio_mixer;

    localparam int NCH     = 4;
    localparam int IN_W    = 16;
    localparam int GAIN_W  = 4;
    localparam int GAIN_SH = 3;
    localparam int OUT_W   = 16;

    logic                  CLKSYS = 1'b0;
    logic                  RESET;
    logic                  sample_stb;
    logic [NCH*IN_W-1:0]   ch_data;
    logic [NCH*GAIN_W-1:0] ch_gain;
    logic [NCH-1:0]        ch_mute;
    logic                  overrun_clr;
    logic [OUT_W-1:0]      mix_out;
    logic                  mix_valid;
    logic                  busy;
    logic                  overrun;
`ifdef AUDIO_MIXER_PEAK_EN
    logic [OUT_W-1:0]      peak_out;
    logic                  peak_clr;
    logic                  clip;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLKSYS = ~CLKSYS;

    audio_mixer #(
        .NCH(NCH), .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_SH(GAIN_SH), .OUT_W(OUT_W)
    ) dut (
        .CLKSYS      (CLKSYS),
        .RESET       (RESET),
        .sample_stb  (sample_stb),
        .ch_data     (ch_data),
        .ch_gain     (ch_gain),
        .ch_mute     (ch_mute),
        .overrun_clr (overrun_clr),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .busy        (busy),
`ifdef AUDIO_MIXER_PEAK_EN
        .peak_out    (peak_out),
        .peak_clr    (peak_clr),
        .clip        (clip),
`endif
        .overrun     (overrun)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLKSYS);
        #1;
    endtask

    task automatic set_ch(input int d0, input int d1, input int d2, input int d3,
                          input int g0, input int g1, input int g2, input int g3,
                          input logic [NCH-1:0] m);
        ch_data = {IN_W'(d3), IN_W'(d2), IN_W'(d1), IN_W'(d0)};
        ch_gain = {GAIN_W'(g3), GAIN_W'(g2), GAIN_W'(g1), GAIN_W'(g0)};
        ch_mute = m;
    endtask

    // Strobe for one cycle; returns in cycle T+1.
    task automatic pulse_stb();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
    endtask

    // Counts cycles (first call position = 1) until mix_valid; lat=0 on timeout.
    task automatic wait_valid(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 30; i++) begin
            if (busy) busy_n++;
            if (mix_valid) begin
                lat = i;
                break;
            end
            tick();
        end
    endtask

    int lat;
    int bn;
    int vcnt;

    initial begin
        RESET       = 1'b1;
        sample_stb  = 1'b0;
        overrun_clr = 1'b0;
`ifdef AUDIO_MIXER_PEAK_EN
        peak_clr    = 1'b0;
`endif
        set_ch(0, 0, 0, 0, 0, 0, 0, 0, '0);
        #1;
        check("rst_mix_out",   mix_out,   0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_overrun",   overrun,   0);
        repeat (2) tick();
        @(negedge CLKSYS);
        RESET = 1'b0;
        tick();

        // Unity gain, plain sum.
        set_ch(1000, 2000, 3000, 4000, 8, 8, 8, 8, 4'b0000);
        pulse_stb();
        wait_valid(lat, bn);
        check("t1_latency", lat, 6);
        check("t1_busy_cycles", bn, 5);
        check("t1_mix_out", mix_out, 10000);
        tick();
        check("t1_valid_one_cycle", mix_valid, 0);
        check("t1_hold", mix_out, 10000);
        check("t1_busy_low", busy, 0);
`ifdef AUDIO_MIXER_PEAK_EN
        check("t1_peak", peak_out, 10000);
        check("t1_clip", clip, 0);
`endif

        // Mixed gains including 0.
        set_ch(800, 800, 800, 800, 15, 8, 4, 0, 4'b0000);
        pulse_stb();
        wait_valid(lat, bn);
        check("t2_latency", lat, 6);
        check("t2_mix_out", mix_out, 2700);

        // Saturation.
        set_ch(65535, 65535, 65535, 65535, 15, 15, 15, 15, 4'b0000);
        pulse_stb();
        wait_valid(lat, bn);
        check("t3_mix_out_sat", mix_out, 65535);
`ifdef AUDIO_MIXER_PEAK_EN
        check("t3_peak", peak_out, 65535);
        check("t3_clip", clip, 1);
        tick();
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        check("t3_peak_clr", peak_out, 0);
        check("t3_clip_clr", clip, 0);
`endif

        // Mute plus input change right after the strobe.
        set_ch(100, 200, 300, 400, 8, 8, 8, 8, 4'b0101);
        pulse_stb();
        set_ch(9999, 9999, 9999, 9999, 15, 15, 15, 15, 4'b0000);
        wait_valid(lat, bn);
        check("t4_mute_shadow", mix_out, 600);
        tick();

        // Strobe while busy: ignored, overrun set.
        set_ch(1000, 2000, 3000, 4000, 8, 8, 8, 8, 4'b0000);
        pulse_stb();
        tick();
        pulse_stb();
        check("t5_overrun_set", overrun, 1);
        check("t5_busy", busy, 1);
        wait_valid(lat, bn);
        check("t5_first_latency", lat, 4);
        check("t5_mix_out", mix_out, 10000);
        // Back-to-back strobe on the mix_valid cycle is accepted.
        set_ch(500, 500, 500, 500, 8, 8, 8, 8, 4'b0000);
        pulse_stb();
        check("t5_b2b_busy", busy, 1);
        wait_valid(lat, bn);
        check("t5_b2b_latency", lat, 6);
        check("t5_b2b_mix_out", mix_out, 2000);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mix_valid) vcnt++;
        end
        check("t5_no_extra_valid", vcnt, 0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("t5_overrun_clr", overrun, 0);
        // Set wins over clear in the same cycle.
        pulse_stb();
        sample_stb  = 1'b1;
        overrun_clr = 1'b1;
        tick();
        sample_stb  = 1'b0;
        overrun_clr = 1'b0;
        check("t5_set_wins", overrun, 1);
        wait_valid(lat, bn);
        check("t5_sw_mix_out", mix_out, 2000);
        tick();

        // Asynchronous reset during ACC cycle 2.
        set_ch(1000, 2000, 3000, 4000, 8, 8, 8, 8, 4'b0000);
        pulse_stb();
        pulse_stb();
        #2;
        RESET = 1'b1;
        #1;
        check("t6_rst_mix_out", mix_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_valid", mix_valid, 0);
        vcnt = 0;
        repeat (3) begin
            tick();
            if (mix_valid) vcnt++;
        end
        @(negedge CLKSYS);
        RESET = 1'b0;
        repeat (8) begin
            tick();
            if (mix_valid) vcnt++;
        end
        check("t6_no_valid", vcnt, 0);
        check("t6_mix_out_zero", mix_out, 0);
        pulse_stb();
        wait_valid(lat, bn);
        check("t6_post_latency", lat, 6);
        check("t6_post_mix_out", mix_out, 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Parametrised N-channel unsigned audio mixer.
- Replaces the fixed shift-and-add summing of tape, PSG, buzzer and relay sound at the top level.
- Each channel has per-channel gain and mute. Channels are accumulated time-multiplexed, one per clock, after a sample strobe.
- The result is saturated to the output width and registered for AUDIO_L/AUDIO_R, with AUDIO_S=0.

Parameters:
NCH, 4, number of input channels (1..16)
IN_W, 16, width of each unsigned channel sample
GAIN_W, 4, width of each per-channel gain code
GAIN_SH, 3, right shift applied to each product (gain code 8 = unity at default)
OUT_W, 16, width of the unsigned mixed output

Ports:
CLKSYS  in  1  system clock
RESET  in  1  asynchronous active-high reset
sample_stb  in  1  one-cycle pulse; start mixing one sample
ch_data  in  NCH*IN_W  channel samples; channel k at [k*IN_W +: IN_W]
ch_gain  in  NCH*GAIN_W  gain codes; channel k at [k*GAIN_W +: GAIN_W]
ch_mute  in  NCH  1 = channel k contributes 0
mix_out  out  OUT_W  last completed mixed sample
mix_valid  out  1  one-cycle pulse when mix_out updates
busy  out  1  high while accumulating
overrun  out  1  sticky; a sample_stb arrived while busy
overrun_clr  in  1  clears overrun

Behaviour:
- Clock and reset: single clock CLKSYS; RESET is asynchronous and active-high.
- Reset values: mix_out=0, mix_valid=0, busy=0, overrun=0, state=IDLE, acc=0, idx=0.
- Accumulator width: AW = IN_W+GAIN_W+clog2(NCH)+1. The accumulator never wraps.
- IDLE:
  - On sample_stb, latch ch_data, ch_gain and ch_mute into shadow registers.
  - Clear acc, set idx=0, go to ACC, and raise busy from the next cycle.
- ACC:
  - Each cycle, acc += mute[idx] ? 0 : ((data[idx]*gain[idx]) >> GAIN_SH). The product is zero-extended to AW.
  - idx increments each cycle. After idx=NCH-1 is added, go to SAT.
  - ACC lasts exactly NCH cycles.
- SAT:
  - mix_out <= (acc > 2^OUT_W-1) ? 2^OUT_W-1 : acc[OUT_W-1:0].
  - Pulse mix_valid for one cycle, drop busy, return to IDLE.
- Latency: strobe at cycle T, mix_valid high in cycle T+NCH+2. Shadow latching means inputs may change any time after T.
- sample_stb in IDLE on the same cycle mix_valid pulses is accepted normally (back-to-back).
- sample_stb while busy (ACC or SAT):
  - The strobe is ignored and the mix in progress is unaffected.
  - overrun is set.
- overrun_clr and a new overrun in the same cycle: set wins.
- mix_out holds its value between completions.
- RESET mid-accumulation: abort immediately to reset values. No mix_valid is produced.
- Gain code 0 is equivalent to mute.

Optional Feature:
- Macro: AUDIO_MIXER_PEAK_EN.
- When defined, the block adds:
  - port peak_out (out, OUT_W): maximum mix_out since reset or the last clear; updated in the same cycle as mix_valid, compared against the new saturated value.
  - port peak_clr (in, 1): sets peak_out=0. If peak_clr coincides with mix_valid, peak_out takes the new mix_out.
  - port clip (out, 1): sticky; set when SAT saturates. Cleared by peak_clr unless a saturation occurs in the same cycle.
- When undefined, none of these ports or registers exist. Core behaviour is identical.

Test Plan:
- Reset, then NCH=4, gains all 8, no mute, data {1000,2000,3000,4000}, strobe -> mix_valid exactly 6 cycles later, mix_out=10000, busy high for 5 cycles.
- Gains {16→use 15,8,4,0}: data all 800, GAIN_W=4 -> (800*15>>3)+(800)+(400)+0 = 1500+800+400 = 2700.
- Data all 65535, gains 15 -> acc exceeds 65535 -> mix_out=65535. With AUDIO_MIXER_PEAK_EN: clip=1, peak_out=65535.
- ch_mute=4'b0101, data {100,200,300,400}, unity gain -> mix_out=600. Change ch_data the cycle after the strobe -> result still 600.
- Strobe, then a second strobe 2 cycles later -> single mix_valid and overrun=1. overrun_clr -> overrun=0. A strobe on the mix_valid cycle is accepted.
- Assert RESET asynchronously during ACC cycle 2 -> all outputs 0 at once, no mix_valid. The next strobe after release mixes correctly.
